action_encoder: RTL and testbench
=================================

# action_encoder

Front-end producer for the fight-game action bus. It debounces the raw push-buttons of both players and captures one action per player per game tick. At each tick it drives a registered one-hot 6-bit action code per player, plus a one-cycle `game_tick` strobe that advances the game-logic core. Between the board's button pins and the game-logic core.

## Interface
- `TICK_CYCLES`, default 50_000_000: clock cycles per game tick, at least 2.
- `DEBOUNCE_CYCLES`, default 500_000: consecutive cycles a raw button must disagree with its debounced value before that value flips, at least 1.

- `clock`  input  1  system clock.
- `reset`  input  1  reset, synchronous, active-high; all state is cleared at the clock edge where it is sampled high.
- `btn1`  input  5  raw buttons, player 1: [4]=Move_Left [3]=Move_Right [2]=Jump [1]=Punch [0]=Kick, active-high, asynchronous to the clock.
- `btn2`  input  5  raw buttons, player 2, same bit map.
- `player1`  output  6  registered one-hot action, player 1.
- `player2`  output  6  registered one-hot action, player 2.
- `game_tick`  output  1  one-cycle strobe; the game core steps on it.

## Operation
- Action encodings:
  - Wait = 100000
  - Move_Left = 010000
  - Move_Right = 001000
  - Jump = 000100
  - Punch = 000010
  - Kick = 000001
- Synchronizer: each raw button passes through 2 flip-flops before entering the debouncer.
- Debouncer: one counter per button (10 total).
  - Each edge where the synced value differs from the stable value, the counter increments.
  - Any agreeing sample clears the counter.
  - On the `DEBOUNCE_CYCLES`-th consecutive differing edge, the stable value flips and the counter clears.
- Press event: a 0→1 transition of a stable button value.
- Per-player capture FSM, two states:
  - EMPTY: any press event latches that action and moves to LATCHED. If several press events occur in one cycle, priority is Punch > Kick > Jump > Move_Left > Move_Right.
  - LATCHED: further press events are ignored (first press wins). Returns to EMPTY on a tick load.
- Tick counter runs 0..`TICK_CYCLES`-1 and wraps. On the wrap edge (a "load"):
  - each player output takes the latched action, or Wait if its FSM is EMPTY;
  - both FSMs return to EMPTY;
  - the outputs then hold for a full tick.
- Press event on the load edge: it is latched into the new window (the FSM goes to LATCHED with that action), never dropped and never issued into the current window.
- Each press is issued at most once. A held button does not re-issue unless `AUTO_REPEAT_EN` is defined.
- Releasing a button has no effect on the outputs.

## Timing
- Reset values:
  - `player1` = `player2` = 100000
  - `game_tick` = 0
  - tick counter = 0
  - debounce counters = 0
  - stable button values = 0
  - synchronizers = 0
  - both FSMs = EMPTY
- Reset mid-tick discards any latched actions. After reset is released, the first load occurs on the `TICK_CYCLES`-th edge.
- `game_tick` is registered and goes high on the edge after a load, for exactly 1 cycle. The actions are therefore stable for at least 1 cycle before and `TICK_CYCLES`-1 cycles after the strobe.
- Press latency, raw to stable: 2 synchronizer edges + `DEBOUNCE_CYCLES` edges.
- Press latency, stable to output: up to `TICK_CYCLES` cycles.
- Players are fully independent; simultaneous activity on both players has no interaction.
- Counter widths: $clog2 of each parameter. No overflow is possible because every counter clears at its terminal count.

## Configuration
- `ACTION_ENCODER_AUTO_REPEAT_EN`
  - Defined: at a load with the FSM EMPTY, if any stable button of that player is high, the highest-priority held action is issued instead of Wait.
  - Undefined: an EMPTY FSM always issues Wait (edge-only behaviour).

## Test plan
All scenarios use `TICK_CYCLES`=8 and `DEBOUNCE_CYCLES`=4.
- Reset held for 3 cycles, no buttons → `player1`=`player2`=100000 throughout. `game_tick` pulses on edges 9, 17, 25 after reset deasserts, for 1 cycle each.
- `btn1[1]` pulses for 3 cycles only → no debounced change; `player1` stays 100000 at every tick.
- `btn1[1]` and `btn1[0]` rise in the same cycle and are held 10 cycles → `player1`=000010 for exactly one tick window, then 100000. With the auto-repeat macro defined, 000010 repeats while the button is held.
- `btn2[4]` pressed, then `btn2[3]` pressed 2 cycles later, both within one window → `player2`=010000 at the next load. The `btn2[3]` press is never issued.
- Stable press event timed onto the load edge → the current window issues its prior content; the next window issues that press.
- Reset asserted while `player1` is LATCHED with Jump → `player1`=100000 at the next edge, and the Jump is never issued.

Source files
------------

// File: rtl/action_encoder.sv
// Debounces both players' push-buttons and captures one action per player per game tick.
// Define ACTION_ENCODER_AUTO_REPEAT_EN to re-issue held buttons at loads when nothing new was latched.
module action_encoder #(
    parameter int TICK_CYCLES     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] btn1,
    input  logic [4:0] btn2,
    output logic [5:0] player1,
    output logic [5:0] player2,
    output logic       game_tick
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [5:0] ACT_WAIT  = 6'b100000;
    localparam logic [5:0] ACT_LEFT  = 6'b010000;
    localparam logic [5:0] ACT_RIGHT = 6'b001000;
    localparam logic [5:0] ACT_JUMP  = 6'b000100;
    localparam logic [5:0] ACT_PUNCH = 6'b000010;
    localparam logic [5:0] ACT_KICK  = 6'b000001;

    typedef enum logic {
        EMPTY   = 1'b0,
        LATCHED = 1'b1
    } capState_t;

    // Highest-priority action among a player's buttons; Wait when none are set.
    function automatic logic [5:0] encodeAction(input logic [4:0] b);
        if (b[1])      return ACT_PUNCH;
        else if (b[0]) return ACT_KICK;
        else if (b[2]) return ACT_JUMP;
        else if (b[4]) return ACT_LEFT;
        else if (b[3]) return ACT_RIGHT;
        else           return ACT_WAIT;
    endfunction

    logic [9:0]    w_raw;
    logic [9:0]    r_sync1;
    logic [9:0]    r_sync2;
    logic [9:0]    r_stable;
    logic [DW-1:0] r_dbCnt [10];
    logic [9:0]    w_press;

    logic [TW-1:0] r_tickCnt;
    logic          w_load;
    logic          r_loadSeen;
    logic          r_gameTick;

    capState_t     r_state      [2];
    capState_t     w_stateNext  [2];
    logic [5:0]    r_action     [2];
    logic [5:0]    w_actionNext [2];
    logic [5:0]    r_out        [2];
    logic [5:0]    w_outNext    [2];
    logic [5:0]    w_pressAct   [2];
    logic [5:0]    w_idle       [2];
    logic [1:0]    w_anyPress;

    assign w_raw = {btn2, btn1};

    // Two-flop synchronizer per raw button.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Stable value flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stable <= '0;
            for (int i = 0; i < 10; i++) r_dbCnt[i] <= '0;
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (r_dbCnt[i] == DB_LAST) begin
                    r_dbCnt[i]  <= '0;
                    r_stable[i] <= r_sync2[i];
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + DW'(1);
                end
            end
        end
    end

    // A press is the edge on which a stable value flips from 0 to 1.
    always_comb begin
        w_press = '0;
        for (int i = 0; i < 10; i++) begin
            w_press[i] = r_sync2[i] && !r_stable[i] && (r_dbCnt[i] == DB_LAST);
        end
    end

    assign w_load = (r_tickCnt == TICK_LAST);

    // game_tick trails the load by one edge so actions settle before the core steps.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tickCnt  <= '0;
            r_loadSeen <= 1'b0;
            r_gameTick <= 1'b0;
        end else begin
            r_tickCnt  <= w_load ? '0 : r_tickCnt + TW'(1);
            r_loadSeen <= w_load;
            r_gameTick <= r_loadSeen;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                r_state[p]  <= EMPTY;
                r_action[p] <= ACT_WAIT;
                r_out[p]    <= ACT_WAIT;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_state[p]  <= w_stateNext[p];
                r_action[p] <= w_actionNext[p];
                r_out[p]    <= w_outNext[p];
            end
        end
    end

    // A press landing on the load edge opens the next window rather than joining the current one.
    always_comb begin
        w_anyPress = '0;
        for (int p = 0; p < 2; p++) begin
            w_pressAct[p]   = encodeAction(w_press[p*5 +: 5]);
            w_anyPress[p]   = |w_press[p*5 +: 5];
`ifdef ACTION_ENCODER_AUTO_REPEAT_EN
            w_idle[p]       = encodeAction(r_stable[p*5 +: 5]);
`else
            w_idle[p]       = ACT_WAIT;
`endif
            w_stateNext[p]  = r_state[p];
            w_actionNext[p] = r_action[p];
            w_outNext[p]    = r_out[p];
            if (w_load) begin
                w_outNext[p]    = (r_state[p] == LATCHED) ? r_action[p] : w_idle[p];
                w_stateNext[p]  = w_anyPress[p] ? LATCHED : EMPTY;
                w_actionNext[p] = w_pressAct[p];
            end else if ((r_state[p] == EMPTY) && w_anyPress[p]) begin
                w_stateNext[p]  = LATCHED;
                w_actionNext[p] = w_pressAct[p];
            end
        end
    end

    assign player1   = r_out[0];
    assign player2   = r_out[1];
    assign game_tick = r_gameTick;

endmodule

// File: tb/tb_action_encoder.sv
// Randomized bench for action_encoder against a window-based reference model of debounce,
// tick windows and first-press capture (TICK_CYCLES=8, DEBOUNCE_CYCLES=4).
module tb_action_encoder;

    localparam int TICK = 8;
    localparam int DB   = 4;
    localparam logic [5:0] WAIT = 6'b100000;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] btn1;
    logic [4:0] btn2;
    logic [5:0] player1;
    logic [5:0] player2;
    logic       game_tick;

    int testCount = 0;
    int failCount = 0;
    int cycle     = 0;

    logic [9:0]  mStable;
    logic [9:0]  mD1;
    logic [9:0]  mD2;
    logic [9:0]  syncQ [$];
    int unsigned mEdge;
    logic [5:0]  mOut     [2];
    logic [5:0]  mPending [2];
    logic        mPrevLoad;
    logic        mTick;

    action_encoder #(.TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DB)) dut (
        .clock    (clock),
        .reset    (reset),
        .btn1     (btn1),
        .btn2     (btn2),
        .player1  (player1),
        .player2  (player2),
        .game_tick(game_tick)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [5:0] observed, input logic [5:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s cycle %0d: got %b, expected %b", tag, cycle, observed, expected);
        end
    endtask

    // Action code is one-hot at the button's index; priority Punch, Kick, Jump, Left, Right.
    function automatic logic [5:0] pickAction(input logic [4:0] b);
        int order [5] = '{1, 0, 2, 4, 3};
        for (int k = 0; k < 5; k++) begin
            if (b[order[k]]) return 6'(1 << order[k]);
        end
        return WAIT;
    endfunction

    // One clock edge of the reference model; a stable bit flips when the last DB synced samples all disagree.
    task automatic modelEdge(input logic rst, input logic [9:0] raw);
        logic [9:0] s;
        logic [9:0] flip;
        logic [9:0] press;
        logic [9:0] oldStable;
        logic [4:0] pa;
        logic       load;
        logic       allDiff;
        if (rst) begin
            mStable = '0; mD1 = '0; mD2 = '0;
            syncQ.delete();
            mEdge = 0; mPrevLoad = 1'b0; mTick = 1'b0;
            for (int p = 0; p < 2; p++) begin
                mOut[p] = WAIT; mPending[p] = '0;
            end
        end else begin
            s = mD2; mD2 = mD1; mD1 = raw;
            syncQ.push_back(s);
            if (syncQ.size() > DB) void'(syncQ.pop_front());
            flip = '0;
            if (syncQ.size() == DB) begin
                for (int i = 0; i < 10; i++) begin
                    allDiff = 1'b1;
                    foreach (syncQ[j]) if (syncQ[j][i] == mStable[i]) allDiff = 1'b0;
                    flip[i] = allDiff;
                end
            end
            oldStable = mStable;
            mStable   = mStable ^ flip;
            press     = flip & mStable;
            mEdge++;
            load      = (mEdge % TICK) == 0;
            mTick     = mPrevLoad;
            mPrevLoad = load;
            for (int p = 0; p < 2; p++) begin
                pa = press[p*5 +: 5];
                if (load) begin
`ifdef ACTION_ENCODER_AUTO_REPEAT_EN
                    mOut[p] = (mPending[p] != 0) ? mPending[p] : pickAction(oldStable[p*5 +: 5]);
`else
                    mOut[p] = (mPending[p] != 0) ? mPending[p] : WAIT;
`endif
                    mPending[p] = (pa != 0) ? pickAction(pa) : 6'b0;
                end else if (mPending[p] == 0 && pa != 0) begin
                    mPending[p] = pickAction(pa);
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [4:0] b1, input logic [4:0] b2);
        reset = rst; btn1 = b1; btn2 = b2;
        @(posedge clock);
        modelEdge(rst, {b2, b1});
        @(negedge clock);
        cycle++;
        checkOutput("player1", player1, mOut[0]);
        checkOutput("player2", player2, mOut[1]);
        checkOutput("game_tick", {5'b0, game_tick}, {5'b0, mTick});
    endtask

    task automatic holdFor(input logic rst, input logic [4:0] b1, input logic [4:0] b2, input int n);
        for (int k = 0; k < n; k++) applyStimulus(rst, b1, b2);
    endtask

    initial begin
        logic [9:0] rawState;
        logic       rst;
        int         pct;
        reset = 1'b1; btn1 = '0; btn2 = '0;
        holdFor(1'b1, 5'b0, 5'b0, 3);
        holdFor(1'b0, 5'b0, 5'b0, 30);
        holdFor(1'b0, 5'b00010, 5'b0, 3);
        holdFor(1'b0, 5'b0, 5'b0, 20);
        holdFor(1'b0, 5'b00011, 5'b0, 10);
        holdFor(1'b0, 5'b0, 5'b0, 30);
        holdFor(1'b0, 5'b0, 5'b10000, 2);
        holdFor(1'b0, 5'b0, 5'b11000, 12);
        holdFor(1'b0, 5'b0, 5'b0, 30);
        holdFor(1'b0, 5'b00100, 5'b0, 12);
        holdFor(1'b1, 5'b00100, 5'b0, 1);
        holdFor(1'b0, 5'b0, 5'b0, 30);

        rawState = '0;
        for (int c = 0; c < 4000; c++) begin
            pct = ((c / 200) % 2 == 0) ? 4 : 25;
            for (int i = 0; i < 10; i++) begin
                if ($urandom_range(99) < pct) rawState[i] = ~rawState[i];
            end
            rst = ($urandom_range(499) == 0);
            applyStimulus(rst, rawState[4:0], rawState[9:5]);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
